// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline datapath.
//   NB_DATA / NB_REG_ADDRESS / N_REGS : register file geometry
//   REG_ZERO / REG_RA                 : hardwired-zero and link register indices
//   dump_state_t                      : register-dump sequencer states
package mips_pkg;
  localparam int NB_DATA        = 32;
  localparam int NB_REG_ADDRESS = 5;
  localparam int N_REGS         = 32;

  localparam logic [NB_REG_ADDRESS-1:0] REG_ZERO = 5'd0;
  localparam logic [NB_REG_ADDRESS-1:0] REG_RA   = 5'd31;

  typedef enum logic {
    DUMP_IDLE = 1'b0,
    DUMP_SEND = 1'b1
  } dump_state_t;
endpackage

// File: rtl/register_dump_seq.sv
// Register dump sequencer: walks indices 0..N_REGS-1 under a valid/ready
// handshake after a start request.
//   i_clock, i_reset : clock, async active-high reset
//   i_start          : begin a dump (ignored while one is running)
//   i_ready          : consumer accepts the current word
//   o_idx            : register index being offered
//   o_valid, o_busy  : word on offer / sequence running (identical here)
//   o_last           : current word is register N_REGS-1
module register_dump_seq #(
  parameter int N_REGS         = mips_pkg::N_REGS,
  parameter int NB_REG_ADDRESS = mips_pkg::NB_REG_ADDRESS
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic                      i_ready,
  output logic [NB_REG_ADDRESS-1:0] o_idx,
  output logic                      o_valid,
  output logic                      o_last,
  output logic                      o_busy
);
  import mips_pkg::*;

  localparam logic [NB_REG_ADDRESS-1:0] LAST_IDX = NB_REG_ADDRESS'(N_REGS - 1);

  dump_state_t               state_q, state_d;
  logic [NB_REG_ADDRESS-1:0] idx_q, idx_d;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    o_last  = 1'b0;
    unique case (state_q)
      DUMP_IDLE: begin
        if (i_start) begin
          state_d = DUMP_SEND;
          idx_d   = '0;
        end
      end
      DUMP_SEND: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        o_last  = (idx_q == LAST_IDX);
        // Exit on the last transfer and park the index at 0 so it never wraps.
        if (i_ready) begin
          if (o_last) begin
            state_d = DUMP_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  assign o_idx = idx_q;
endmodule

// File: rtl/register_file.sv
// 32-entry MIPS general-purpose register file with write-through bypass
// and a debug dump port.
//   i_clock, i_reset            : clock, async active-high reset (clears array)
//   i_enable                    : pipeline step enable; gates writes and bypass
//   i_reg_write/_addr/_data     : write-back port (r0 writes dropped)
//   i_read_addr_a/b, o_read_data_a/b : combinational rs/rt reads
//   i_dump_start, i_dump_ready  : dump request / consumer ready
//   o_dump_valid/data/addr/last/busy : dump word stream (data/addr zero when idle)
module register_file #(
  parameter int NB_DATA        = mips_pkg::NB_DATA,
  parameter int NB_REG_ADDRESS = mips_pkg::NB_REG_ADDRESS,
  parameter int N_REGS         = mips_pkg::N_REGS
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_reg_write,
  input  logic [NB_REG_ADDRESS-1:0] i_write_addr,
  input  logic [NB_DATA-1:0]        i_write_data,
  input  logic [NB_REG_ADDRESS-1:0] i_read_addr_a,
  input  logic [NB_REG_ADDRESS-1:0] i_read_addr_b,
  output logic [NB_DATA-1:0]        o_read_data_a,
  output logic [NB_DATA-1:0]        o_read_data_b,
  input  logic                      i_dump_start,
  input  logic                      i_dump_ready,
  output logic                      o_dump_valid,
  output logic [NB_DATA-1:0]        o_dump_data,
  output logic [NB_REG_ADDRESS-1:0] o_dump_addr,
  output logic                      o_dump_last,
  output logic                      o_dump_busy
);
  import mips_pkg::*;

  logic [NB_DATA-1:0]        regs [N_REGS];
  logic                      wr_en;
  logic [NB_REG_ADDRESS-1:0] dump_idx;

  assign wr_en = i_enable & i_reg_write & (i_write_addr != REG_ZERO);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[i_write_addr] <= i_write_data;
    end
  end

  // Same-cycle WB->ID forwarding; r0 wins over the bypass.
  always_comb begin
    o_read_data_a = regs[i_read_addr_a];
    if (wr_en && (i_read_addr_a == i_write_addr)) o_read_data_a = i_write_data;
    if (i_read_addr_a == REG_ZERO) o_read_data_a = '0;

    o_read_data_b = regs[i_read_addr_b];
    if (wr_en && (i_read_addr_b == i_write_addr)) o_read_data_b = i_write_data;
    if (i_read_addr_b == REG_ZERO) o_read_data_b = '0;
  end

  register_dump_seq #(
    .N_REGS        (N_REGS),
    .NB_REG_ADDRESS(NB_REG_ADDRESS)
  ) u_dump_seq (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_start(i_dump_start),
    .i_ready(i_dump_ready),
    .o_idx  (dump_idx),
    .o_valid(o_dump_valid),
    .o_last (o_dump_last),
    .o_busy (o_dump_busy)
  );

  // Dump shows stored contents only (no bypass); zero outside a dump.
  assign o_dump_addr = o_dump_valid ? dump_idx : '0;
  assign o_dump_data = o_dump_valid ? regs[dump_idx] : '0;
endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
  logic        clk, rst, en, we, start, rdy;
  logic [4:0]  wa, ra_a, ra_b;
  logic [31:0] wd;
  logic [31:0] rd_a, rd_b, d_data;
  logic [4:0]  d_addr;
  logic        d_valid, d_last, d_busy;

  int checks = 0;
  int failures = 0;

  register_file dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_reg_write(we),
    .i_write_addr(wa), .i_write_data(wd),
    .i_read_addr_a(ra_a), .i_read_addr_b(ra_b),
    .o_read_data_a(rd_a), .o_read_data_b(rd_b),
    .i_dump_start(start), .i_dump_ready(rdy),
    .o_dump_valid(d_valid), .o_dump_data(d_data), .o_dump_addr(d_addr),
    .o_dump_last(d_last), .o_dump_busy(d_busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mregs [32];
  bit          m_busy;
  int          m_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 0;
      m_busy = 0;
      m_idx  = 0;
    end else begin
      if (m_busy) begin
        if (rdy) begin
          if (m_idx == 31) begin m_busy = 0; m_idx = 0; end
          else m_idx = m_idx + 1;
        end
      end else if (start) begin
        m_busy = 1;
        m_idx  = 0;
      end
      if (en && we && wa != 0) mregs[wa] = wd;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (ra == 0) return 0;
    if (en && we && wa != 0 && ra == wa) return wd;
    return mregs[ra];
  endfunction

  always @(negedge clk) begin
    chk("read_a", rd_a, exp_rd(ra_a));
    chk("read_b", rd_b, exp_rd(ra_b));
    chk("dump_valid", {31'b0, d_valid}, {31'b0, m_busy});
    chk("dump_busy", {31'b0, d_busy}, {31'b0, m_busy});
    if (m_busy) begin
      chk("dump_addr", {27'b0, d_addr}, m_idx);
      chk("dump_data", d_data, mregs[m_idx]);
      chk("dump_last", {31'b0, d_last}, {31'b0, m_idx == 31});
    end else begin
      chk("idle_addr", {27'b0, d_addr}, 0);
      chk("idle_data", d_data, 0);
      chk("idle_last", {31'b0, d_last}, 0);
    end
  end

  // Transfer log for ordering checks
  typedef struct { logic [4:0] a; logic [31:0] d; logic l; } xfer_t;
  xfer_t xq[$];
  always @(posedge clk)
    if (!rst && d_valid && rdy) xq.push_back(xfer_t'{d_addr, d_data, d_last});

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, xq.size(), 32);
    for (int i = 0; i < xq.size() && i < 32; i++) begin
      chk({tag, "_addr"}, {27'b0, xq[i].a}, i);
      chk({tag, "_data"}, xq[i].d, i * 32'h11);
      chk({tag, "_last"}, {31'b0, xq[i].l}, {31'b0, i == 31});
    end
  endtask

  initial begin
    rst = 1; en = 0; we = 0; start = 0; rdy = 0;
    wa = 0; wd = 0; ra_a = 3; ra_b = 9;
    #12;
    chk("reset_rd_a", rd_a, 0);
    chk("reset_busy", {31'b0, d_busy}, 0);
    step();
    rst = 0;

    // Write r5, read next cycle
    en = 1; we = 1; wa = 5; wd = 32'hDEADBEEF;
    step();
    we = 0; ra_a = 5; ra_b = 6; #1;
    chk("r5_read", rd_a, 32'hDEADBEEF);
    chk("r6_read", rd_b, 0);

    // r0 writes are discarded
    we = 1; wa = 0; wd = 32'h12345678; ra_a = 0; #1;
    chk("r0_same_cycle", rd_a, 0);
    step();
    we = 0; #1;
    chk("r0_after", rd_a, 0);

    // Bypass
    we = 1; wa = 7; wd = 32'hA5A5A5A5; ra_b = 7; #1;
    chk("bypass_b", rd_b, 32'hA5A5A5A5);
    step();
    en = 0; we = 1; wa = 7; wd = 32'h0F0F0F0F; #1;
    chk("no_bypass_disabled", rd_b, 32'hA5A5A5A5);
    step();
    en = 1; we = 0; #1;
    chk("no_write_disabled", rd_b, 32'hA5A5A5A5);

    // Preload and full-speed dump
    for (int n = 1; n < 32; n++) begin
      we = 1; wa = 5'(n); wd = n * 32'h11;
      step();
    end
    we = 0;
    xq.delete();
    start = 1; rdy = 1;
    step();
    start = 0;
    for (int c = 0; c < 100 && xq.size() < 32; c++) step();
    chk("busy_after_last", {31'b0, d_busy}, 0);
    check_log("dump_full");

    // Dump with ready toggling and a stray start pulse
    xq.delete();
    start = 1; rdy = 0;
    step();
    start = 0;
    for (int c = 0; c < 300 && xq.size() < 32; c++) begin
      rdy   = (c % 3 == 0);
      start = (c == 10);
      step();
    end
    rdy = 0; start = 0;
    check_log("dump_toggle");
    step();
    chk("toggle_idle", {31'b0, d_busy}, 0);

    // Async reset mid-dump
    start = 1; rdy = 1;
    step();
    start = 0;
    for (int c = 0; c < 50; c++) begin
      if (d_valid && d_addr == 10) break;
      step();
    end
    chk("reached_addr10", {27'b0, d_addr}, 10);
    #2 rst = 1;
    #1;
    chk("rst_busy", {31'b0, d_busy}, 0);
    chk("rst_valid", {31'b0, d_valid}, 0);
    ra_a = 5; ra_b = 31; #1;
    chk("rst_r5", rd_a, 0);
    chk("rst_r31", rd_b, 0);
    step();
    rst = 0;
    start = 1; rdy = 0;
    step();
    start = 0;
    chk("restart_valid", {31'b0, d_valid}, 1);
    chk("restart_addr", {27'b0, d_addr}, 0);
    rdy = 1;
    for (int c = 0; c < 100 && d_busy; c++) step();

    // Randomized traffic, including writes during dumps
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom_range(0, 3) != 0);
      we    = $urandom_range(0, 1);
      wa    = 5'($urandom_range(0, 31));
      wd    = $urandom;
      ra_a  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra_b  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      start = ($urandom_range(0, 15) == 0);
      rdy   = $urandom_range(0, 1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
